// File: rtl/vdp_sprite_vram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vdp_sprite_vram_arbiter_if
// Description : Requester handshakes, dot timing and VRAM port bundled for
//               the sprite VRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vdp_sprite_vram_arbiter_if #(
    parameter int ADDR_W = 17
);
    logic [1:0]        dot_state;
    logic              sp_y_test_state;

    logic              yt_req;
    logic [ADDR_W-1:0] yt_a;
    logic              yt_ack;

    logic              si_req;
    logic [ADDR_W-1:0] si_a;
    logic              si_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_a;
    logic [7:0]        cpu_d;
    logic              cpu_ack;
    logic [7:0]        cpu_q;

    logic [7:0]        vram_q;
    logic [ADDR_W-1:0] vram_a;
    logic              vram_we;
    logic [7:0]        vram_d;

    // Environment side: timing source, requesters and the VRAM device.
    modport master (
        output dot_state, sp_y_test_state,
        output yt_req, yt_a, si_req, si_a,
        output cpu_req, cpu_we, cpu_a, cpu_d,
        output vram_q,
        input  yt_ack, si_ack, cpu_ack, cpu_q,
        input  vram_a, vram_we, vram_d
    );

    modport slave (
        input  dot_state, sp_y_test_state,
        input  yt_req, yt_a, si_req, si_a,
        input  cpu_req, cpu_we, cpu_a, cpu_d,
        input  vram_q,
        output yt_ack, si_ack, cpu_ack, cpu_q,
        output vram_a, vram_we, vram_d
    );
endinterface
`default_nettype wire

// File: rtl/vdp_sprite_vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vdp_sprite_vram_arbiter
// Description : One VRAM access per 4-phase dot slot, shared between sprite
//               Y-test scan, sprite info fetch and CPU, with CPU anti-starve.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_sprite_vram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int STARVE_LIMIT = 4
) (
    input wire                       clk21m,
    input wire                       reset_n,
    vdp_sprite_vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_YT   = 2'd1,
        GNT_SI   = 2'd2,
        GNT_CPU  = 2'd3
    } grant_t;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    grant_t            r_grant;
    logic [3:0]        r_starve_cnt;
    logic [ADDR_W-1:0] r_vram_a;
    logic              r_vram_we;
    logic [7:0]        r_vram_d;
    logic [7:0]        r_cpu_q;
    logic              r_yt_ack;
    logic              r_si_ack;
    logic              r_cpu_ack;

    grant_t            w_winner;
    logic [ADDR_W-1:0] w_winner_a;
    logic              w_slot_start;
    logic              w_ack_edge;
    logic              w_starved;

    assign w_slot_start = (bus.dot_state == 2'b00);
    assign w_ack_edge   = (bus.dot_state == 2'b11);
    assign w_starved    = (r_starve_cnt == c_STARVE_MAX);

    always_comb begin
        w_winner = GNT_NONE;
        if (w_starved && bus.cpu_req) begin
            w_winner = GNT_CPU;
        end else if (bus.sp_y_test_state) begin
            if (bus.yt_req)       w_winner = GNT_YT;
            else if (bus.cpu_req) w_winner = GNT_CPU;
            else if (bus.si_req)  w_winner = GNT_SI;
        end else begin
            if (bus.si_req)       w_winner = GNT_SI;
            else if (bus.cpu_req) w_winner = GNT_CPU;
            else if (bus.yt_req)  w_winner = GNT_YT;
        end
    end

    always_comb begin
        w_winner_a = r_vram_a;
        case (w_winner)
            GNT_YT:  w_winner_a = bus.yt_a;
            GNT_SI:  w_winner_a = bus.si_a;
            GNT_CPU: w_winner_a = bus.cpu_a;
            default: w_winner_a = r_vram_a;
        endcase
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            r_grant      <= GNT_NONE;
            r_starve_cnt <= 4'd0;
            r_vram_a     <= '0;
            r_vram_we    <= 1'b0;
            r_vram_d     <= 8'd0;
            r_cpu_q      <= 8'd0;
            r_yt_ack     <= 1'b0;
            r_si_ack     <= 1'b0;
            r_cpu_ack    <= 1'b0;
        end else begin
            r_yt_ack  <= 1'b0;
            r_si_ack  <= 1'b0;
            r_cpu_ack <= 1'b0;

            if (w_slot_start) begin
                r_grant   <= w_winner;
                r_vram_a  <= w_winner_a;
                r_vram_we <= (w_winner == GNT_CPU) ? bus.cpu_we : 1'b0;
                if (w_winner == GNT_CPU) begin
                    r_vram_d <= bus.cpu_d;
                end
                // A pending CPU that loses ages toward the forced win.
                if (bus.cpu_req && (w_winner != GNT_CPU)) begin
                    if (!w_starved) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end else begin
                    r_starve_cnt <= 4'd0;
                end
            end else if (w_ack_edge) begin
                r_vram_we <= 1'b0;
                r_grant   <= GNT_NONE;
                case (r_grant)
                    GNT_YT:  r_yt_ack  <= 1'b1;
                    GNT_SI:  r_si_ack  <= 1'b1;
                    GNT_CPU: r_cpu_ack <= 1'b1;
                    default: ;
                endcase
                // Write strobe still high here means the CPU slot was a write.
                if ((r_grant == GNT_CPU) && !r_vram_we) begin
                    r_cpu_q <= bus.vram_q;
                end
            end
        end
    end

    assign bus.vram_a  = r_vram_a;
    assign bus.vram_we = r_vram_we;
    assign bus.vram_d  = r_vram_d;
    assign bus.cpu_q   = r_cpu_q;
    assign bus.yt_ack  = r_yt_ack;
    assign bus.si_ack  = r_si_ack;
    assign bus.cpu_ack = r_cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_vdp_sprite_vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vdp_sprite_vram_arbiter
// Description : Scenario bench for the sprite VRAM arbiter with an
//               expected-access queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_sprite_vram_arbiter;

    localparam int ADDR_W = 17;
    localparam logic [1:0] c_NONE = 2'd0, c_YT = 2'd1, c_SI = 2'd2, c_CPU = 2'd3;
    localparam logic [ADDR_W-1:0] c_YT_A  = 17'h01E00;
    localparam logic [ADDR_W-1:0] c_SI_A  = 17'h0F800;
    localparam logic [ADDR_W-1:0] c_CPU_A = 17'h00100;

    // Row encoding: {sp_y_test_state, yt_req, si_req, cpu_req, winner[1:0]}
    localparam logic [5:0] c_TBL [16] = '{
        {4'b1100, c_YT},  {4'b1100, c_YT},  {4'b1111, c_YT},  {4'b0111, c_SI},
        {4'b0010, c_SI},  {4'b0011, c_SI},  {4'b0011, c_SI},  {4'b0011, c_SI},
        {4'b0011, c_SI},  {4'b0011, c_CPU}, {4'b0011, c_SI},  {4'b0001, c_CPU},
        {4'b1011, c_CPU}, {4'b0101, c_CPU}, {4'b0100, c_YT},  {4'b0000, c_NONE}
    };

    typedef struct {
        logic [1:0]        who;
        logic [ADDR_W-1:0] a;
        logic              we;
        logic [7:0]        d;
        logic [7:0]        q;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic clk21m  = 1'b0;
    logic reset_n = 1'b0;

    vdp_sprite_vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    vdp_sprite_vram_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk21m  (clk21m),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial forever #5 clk21m = ~clk21m;

    // Free-running dot phase 00 -> 01 -> 11 -> 10.
    initial begin
        bus.dot_state = 2'b00;
        forever begin
            @(posedge clk21m);
            #1 bus.dot_state = {bus.dot_state[0], ~bus.dot_state[1]};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] ack_vec(input logic [1:0] who);
        case (who)
            c_YT:    return 3'b100;
            c_SI:    return 3'b010;
            c_CPU:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic idle_reqs();
        bus.yt_req  = 1'b0;
        bus.si_req  = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    // Returns at the negedge right before a slot-start clock edge.
    task automatic sync_slot();
        do @(negedge clk21m); while (bus.dot_state != 2'b00);
    endtask

    task automatic test_reset();
        logic seen_ack;
        reset_n = 1'b0;
        idle_reqs();
        repeat (3) @(negedge clk21m);
        checks++;
        if ({bus.vram_a, bus.vram_we, bus.vram_d} !== '0) begin
            errors++;
            $display("FAIL reset_vram: got a=%h we=%b d=%h required 0", bus.vram_a, bus.vram_we, bus.vram_d);
        end
        checks++;
        if ({bus.cpu_q, bus.yt_ack, bus.si_ack, bus.cpu_ack} !== '0) begin
            errors++;
            $display("FAIL reset_ack: got cpu_q=%h acks=%b%b%b required 0", bus.cpu_q, bus.yt_ack, bus.si_ack, bus.cpu_ack);
        end
        reset_n = 1'b1;
        seen_ack = 1'b0;
        repeat (8) begin
            @(negedge clk21m);
            if (bus.yt_ack || bus.si_ack || bus.cpu_ack || bus.vram_we) seen_ack = 1'b1;
        end
        checks++;
        if (seen_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got activity=%b required 0", seen_ack);
        end
    endtask

    task automatic test_arbitration();
        exp_t              e;
        logic [5:0]        r;
        logic [ADDR_W-1:0] last_a;
        last_a = '0;
        bus.yt_a  = c_YT_A;
        bus.si_a  = c_SI_A;
        bus.cpu_a = c_CPU_A;
        bus.cpu_d = 8'h00;
        for (int i = 0; i < 16; i++) begin
            sync_slot();
            r = c_TBL[i];
            bus.sp_y_test_state = r[5];
            bus.yt_req  = r[4];
            bus.si_req  = r[3];
            bus.cpu_req = r[2];
            bus.cpu_we  = 1'b0;
            bus.vram_q  = 8'(i * 13 + 7);
            e.who = r[1:0];
            e.a   = (e.who == c_YT) ? c_YT_A : (e.who == c_SI) ? c_SI_A :
                    (e.who == c_CPU) ? c_CPU_A : last_a;
            e.we  = 1'b0;
            e.d   = 8'h00;
            e.q   = bus.vram_q;
            last_a = e.a;
            sb.push_back(e);

            @(negedge clk21m);
            idle_reqs();
            checks++;
            if (bus.vram_a !== sb[0].a) begin
                errors++;
                $display("FAIL arb_addr row %0d: got %h required %h", i, bus.vram_a, sb[0].a);
            end
            checks++;
            if (bus.vram_we !== sb[0].we) begin
                errors++;
                $display("FAIL arb_we row %0d: got %b required %b", i, bus.vram_we, sb[0].we);
            end

            @(negedge clk21m);
            checks++;
            if ({bus.yt_ack, bus.si_ack, bus.cpu_ack} !== 3'b000) begin
                errors++;
                $display("FAIL arb_early_ack row %0d: got %b required 000", i, {bus.yt_ack, bus.si_ack, bus.cpu_ack});
            end

            @(negedge clk21m);
            e = sb.pop_front();
            checks++;
            if ({bus.yt_ack, bus.si_ack, bus.cpu_ack} !== ack_vec(e.who)) begin
                errors++;
                $display("FAIL arb_ack row %0d: got %b required %b", i, {bus.yt_ack, bus.si_ack, bus.cpu_ack}, ack_vec(e.who));
            end
            if (e.who == c_CPU) begin
                checks++;
                if (bus.cpu_q !== e.q) begin
                    errors++;
                    $display("FAIL arb_cpu_q row %0d: got %h required %h", i, bus.cpu_q, e.q);
                end
            end
        end
    endtask

    task automatic test_cpu_write();
        exp_t e;
        sync_slot();
        bus.sp_y_test_state = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        bus.cpu_a   = 17'h00100;
        bus.cpu_d   = 8'hA5;
        e.who = c_CPU; e.a = 17'h00100; e.we = 1'b1; e.d = 8'hA5; e.q = 8'h00;
        sb.push_back(e);
        @(negedge clk21m);
        idle_reqs();
        checks++;
        if ({bus.vram_a, bus.vram_we, bus.vram_d} !== {sb[0].a, sb[0].we, sb[0].d}) begin
            errors++;
            $display("FAIL wr_start: got a=%h we=%b d=%h required a=%h we=%b d=%h",
                     bus.vram_a, bus.vram_we, bus.vram_d, sb[0].a, sb[0].we, sb[0].d);
        end
        @(negedge clk21m);
        checks++;
        if (bus.vram_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_we_2nd: got %b required 1", bus.vram_we);
        end
        @(negedge clk21m);
        e = sb.pop_front();
        checks++;
        if ({bus.vram_we, bus.cpu_ack} !== 2'b01) begin
            errors++;
            $display("FAIL wr_ack: got we=%b ack=%b required we=0 ack=1", bus.vram_we, bus.cpu_ack);
        end
        @(negedge clk21m);
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack_width: got %b required 0", bus.cpu_ack);
        end
    endtask

    task automatic test_cpu_read();
        exp_t e;
        sync_slot();
        bus.sp_y_test_state = 1'b0;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        bus.cpu_a   = 17'h12345;
        bus.vram_q  = 8'd216;
        e.who = c_CPU; e.a = 17'h12345; e.we = 1'b0; e.d = 8'hA5; e.q = 8'd216;
        sb.push_back(e);
        @(negedge clk21m);
        idle_reqs();
        checks++;
        if ({bus.vram_a, bus.vram_we} !== {sb[0].a, sb[0].we}) begin
            errors++;
            $display("FAIL rd_start: got a=%h we=%b required a=%h we=%b", bus.vram_a, bus.vram_we, sb[0].a, sb[0].we);
        end
        @(negedge clk21m);
        @(negedge clk21m);
        e = sb.pop_front();
        checks++;
        if ({bus.cpu_ack, bus.cpu_q} !== {1'b1, e.q}) begin
            errors++;
            $display("FAIL rd_ack: got ack=%b q=%0d required ack=1 q=%0d", bus.cpu_ack, bus.cpu_q, e.q);
        end
        bus.vram_q = 8'h00;
        repeat (3) @(negedge clk21m);
        checks++;
        if ({bus.cpu_ack, bus.cpu_q} !== {1'b0, e.q}) begin
            errors++;
            $display("FAIL rd_hold: got ack=%b q=%0d required ack=0 q=%0d", bus.cpu_ack, bus.cpu_q, e.q);
        end
    endtask

    task automatic test_reset_midslot();
        logic seen;
        sync_slot();
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        bus.cpu_a   = 17'h00155;
        bus.cpu_d   = 8'h3C;
        @(negedge clk21m);
        idle_reqs();
        checks++;
        if (bus.vram_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_we: got %b required 1", bus.vram_we);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.vram_a, bus.vram_we, bus.vram_d, bus.cpu_q} !== '0) begin
            errors++;
            $display("FAIL rst_async: got a=%h we=%b d=%h q=%h required 0", bus.vram_a, bus.vram_we, bus.vram_d, bus.cpu_q);
        end
        repeat (2) @(negedge clk21m);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk21m);
            if (bus.yt_ack || bus.si_ack || bus.cpu_ack || bus.vram_we) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_ack: got activity=%b required 0", seen);
        end
    endtask

    initial begin
        bus.sp_y_test_state = 1'b0;
        bus.yt_a   = '0;
        bus.si_a   = '0;
        bus.cpu_a  = '0;
        bus.cpu_d  = 8'h00;
        bus.vram_q = 8'h00;
        idle_reqs();
        test_reset();
        test_arbitration();
        test_cpu_write();
        test_cpu_read();
        test_reset_midslot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vdp_sprite_vram_arbiter.md
Name: vdp_sprite_vram_arbiter

Overview:
- Shares the single VRAM port between three requesters: the sprite Y-test attribute scan, the sprite info/pattern fetch, and CPU access.
- Issues at most one access per dot slot, framed by the 4-phase dot_state sequence 00→01→11→10.
- Phase priority follows sp_y_test_state.
- Sits between the sprite sub-blocks and the VRAM interface. It returns per-requester acknowledge strobes aligned to valid vram_q.

Parameters:
- ADDR_W, 17, VRAM address width.
- STARVE_LIMIT, 4, number of consecutive lost slots after which a pending CPU request is forced to win (range 1..15).

Ports:
- clk21m  in  1  system clock, 21.48 MHz
- reset_n  in  1  asynchronous, active-low reset
- dot_state  in  2  dot phase, sequence 00,01,11,10
- sp_y_test_state  in  1  1 = Y-test phase active
- yt_req  in  1  Y-test read request
- yt_a  in  ADDR_W  Y-test address
- yt_ack  out  1  Y-test data valid on vram_q
- si_req  in  1  sprite-info read request
- si_a  in  ADDR_W  sprite-info address
- si_ack  out  1  sprite-info data valid on vram_q
- cpu_req  in  1  CPU request
- cpu_we  in  1  CPU write enable (1 = write)
- cpu_a  in  ADDR_W  CPU address
- cpu_d  in  8  CPU write data
- cpu_ack  out  1  CPU access complete
- cpu_q  out  8  CPU read data, captured at cpu_ack
- vram_q  in  8  VRAM read data
- vram_a  out  ADDR_W  VRAM address
- vram_we  out  1  VRAM write strobe
- vram_d  out  8  VRAM write data

Behaviour:
- Reset values (asynchronous on reset_n=0):
  - vram_a=0, vram_we=0, vram_d=0, cpu_q=0.
  - All acks=0, grant register=none, starve counter=0.
- Slot start: a clock edge where the sampled dot_state==00.
  - Requests are sampled only at slot start.
  - Arbitration is combinational on the sampled requests; the result is registered.
- Priority when sp_y_test_state=1: yt > cpu > si.
- Priority when sp_y_test_state=0: si > cpu > yt.
- Starvation override: if starve_cnt==STARVE_LIMIT and cpu_req=1, cpu wins regardless of phase priority.
- On a granted slot start:
  - vram_a <= winner address.
  - If the winner is cpu: vram_we <= cpu_we and vram_d <= cpu_d.
  - If the winner is not cpu: vram_we <= 0.
  - The grant register is set to the winner.
- No request at slot start: grant=none; vram_a holds its value; vram_we <= 0.
- vram_we timing: deasserted at the edge where sampled dot_state==11, so the write pulse is 2 clocks wide.
- Ack: at the edge where sampled dot_state==11, the granted requester's ack is asserted for exactly 1 clock.
  - In that ack cycle, vram_q is valid.
  - For a cpu read, cpu_q <= vram_q is latched on the same edge.
  - Grant clears after the ack.
- Latency: slot start to ack is 2 clocks. Each requester gets at most 1 access per 4 clocks.
- Requester protocol:
  - Hold req and address stable until ack.
  - Deasserting req after grant does not cancel the access; ack still pulses.
  - Requests at non-slot-start edges wait for the next slot.
- Starve counter (4-bit):
  - +1 at a slot start where cpu_req=1 and cpu loses; saturates at STARVE_LIMIT.
  - Cleared when cpu is granted or when cpu_req=0 at slot start.
- sp_y_test_state changing between slots: takes effect at the next slot start. Mid-slot changes do not alter the current grant.
- Illegal dot_state transitions: the arbiter only reacts to the sampled values 00 and 11; no recovery logic.
- Reset mid-slot: the access is aborted, no ack is emitted, and vram_we drops immediately.

Test Plan:
- Only yt_req=1, yt_a=0x1E00, sp_y_test_state=1:
  - vram_a=0x1E00 one clock after slot start.
  - yt_ack pulses 2 clocks after slot start with vram_q=208; repeats every 4 clocks.
- yt_req=si_req=cpu_req=1:
  - sp_y_test_state=1 → yt granted.
  - Switch to 0 between slots → si granted at the next slot; cpu starves.
- Starvation: si_req and cpu_req held with sp_y_test_state=0, STARVE_LIMIT=4:
  - si wins 4 slots, cpu wins the 5th slot, then the counter resets to 0.
- CPU write cpu_a=0x00100, cpu_d=0xA5 with no other requests:
  - vram_we=1 for 2 clocks with vram_d=0xA5; cpu_ack pulses.
- CPU read with vram_q=216: cpu_ack pulses and cpu_q=216 holds afterwards.
- Assert reset_n=0 one clock after a granted slot start:
  - All outputs go to reset values asynchronously; no ack appears after release.
